// File: rtl/regfile_dump_if.sv
// Handshake/bus bundle between the register-file dump reader and its
// surroundings: control inputs, the third register-file read port and the
// {index, value} output stream.
interface regfile_dump_if #(
  parameter int AW = 5,
  parameter int DW = 32
);
  logic          start;
  logic          abort;
  logic [AW-1:0] lo;
  logic [AW-1:0] hi;
  logic [AW-1:0] ra;
  logic [DW-1:0] rd;
  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] out_addr;
  logic [DW-1:0] out_data;
  logic          busy;
  logic          done;

  // Environment side: control, register-file read data and stream consumer.
  modport master (
    output start, abort, lo, hi, rd, out_ready,
    input  ra, out_valid, out_addr, out_data, busy, done
  );

  // Dump reader side.
  modport slave (
    input  start, abort, lo, hi, rd, out_ready,
    output ra, out_valid, out_addr, out_data, busy, done
  );
endinterface

// File: rtl/regfile_dump.sv
// Sequential register-file reader: walks indices lo..hi through one
// combinational read port and streams {index, value} pairs over valid/ready.
// Never writes the register file.
module regfile_dump #(
  parameter int AW = 5,
  parameter int DW = 32
) (
  input logic          clk,
  input logic          rst,
  regfile_dump_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    SEND,
    FIN
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] ra_q, ra_d;
  logic [AW-1:0] last_q, last_d;
  logic [AW-1:0] out_addr_q, out_addr_d;
  logic [DW-1:0] out_data_q, out_data_d;
  logic          out_valid_q, out_valid_d;

  logic          handshake;

  assign handshake = out_valid_q & bus.out_ready;

  // State register and datapath flops; reset clears everything immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      ra_q        <= '0;
      last_q      <= '0;
      out_addr_q  <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ra_q        <= ra_d;
      last_q      <= last_d;
      out_addr_q  <= out_addr_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Next-state and datapath update; abort overrides every other transition.
  always_comb begin
    state_d     = state_q;
    ra_d        = ra_q;
    last_d      = last_q;
    out_addr_d  = out_addr_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (bus.lo <= bus.hi) begin
            last_d  = bus.hi;
            ra_d    = bus.lo;
            state_d = READ;
          end else begin
            state_d = FIN;
          end
        end
      end
      READ: begin
        out_data_d  = bus.rd;
        out_addr_d  = ra_q;
        out_valid_d = 1'b1;
        state_d     = SEND;
      end
      SEND: begin
        if (handshake) begin
          out_valid_d = 1'b0;
          if (ra_q == last_q) begin
            state_d = FIN;
          end else begin
            ra_d    = ra_q + AW'(1);
            state_d = READ;
          end
        end
      end
      FIN: begin
        state_d = IDLE;
      end
    endcase

    // Abort freezes the datapath (including a start seen in IDLE) and only
    // drops the valid flag, so the presented word keeps its last value.
    if (bus.abort) begin
      state_d     = IDLE;
      ra_d        = ra_q;
      last_d      = last_q;
      out_addr_d  = out_addr_q;
      out_data_d  = out_data_q;
      out_valid_d = 1'b0;
    end
  end

  assign bus.ra        = ra_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_addr  = out_addr_q;
  assign bus.out_data  = out_data_q;
  assign bus.busy      = (state_q == READ) || (state_q == SEND);
  // An abort landing in the FIN cycle suppresses the completion pulse.
  assign bus.done      = (state_q == FIN) && !bus.abort;

endmodule

// File: tb/tb_regfile_dump.sv
// Directed plus randomized bench for regfile_dump: the register file is a
// plain array here, and each dump's expected stream is the list of
// {i, regs[i]} for i in lo..hi taken at start time.
module tb_regfile_dump;

  logic clk;
  logic rst;
  logic [31:0] regs [32];

  int n_vec = 0;
  int n_err = 0;

  regfile_dump_if #(.AW(5), .DW(32)) bus ();

  regfile_dump #(.AW(5), .DW(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // Register file read port: index 0 reads as zero.
  assign bus.rd = (bus.ra == 5'd0) ? 32'd0 : regs[bus.ra];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // stall_pct < 0: ready held low for the first 5 valid cycles of each word.
  task automatic run_dump(input int l, input int h, input int stall_pct, input int abort_word,
                          input bit wr8, input bit noise_start, input string tag);
    logic [31:0] exp_d [$];
    int n_exp, n_hs, done_cyc, busy_cyc, wait_cnt;
    bit aborted, finished, wrote, stalled_prev;
    n_exp = (l <= h) ? (h - l + 1) : 0;
    n_hs = 0; done_cyc = -1; busy_cyc = 0; wait_cnt = 0;
    aborted = 0; finished = 0; wrote = 0; stalled_prev = 0;
    for (int i = l; i <= h; i++) exp_d.push_back((i == 0) ? 32'd0 : regs[i]);
    if (wr8 && l <= 8 && h >= 8) exp_d[8 - l] = 32'hDEADBEEF;

    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (c == 0) begin
        bus.start = 1'b1;
        bus.lo    = 5'(l);
        bus.hi    = 5'(h);
      end else if (noise_start) begin
        bus.start = 1'($urandom_range(1));
        bus.lo    = 5'($urandom);
        bus.hi    = 5'($urandom);
      end else begin
        bus.start = 1'b0;
      end
      if (stall_pct < 0) begin
        bus.out_ready = bus.out_valid && (wait_cnt >= 5);
        if (bus.out_valid) wait_cnt++;
      end else begin
        bus.out_ready = ($urandom_range(99) >= stall_pct);
      end
      bus.abort = 1'b0;
      #1;
      if (aborted) begin
        check({tag, " valid after abort"}, 32'(bus.out_valid), 32'd0);
        check({tag, " busy after abort"}, 32'(bus.busy), 32'd0);
        check({tag, " done after abort"}, 32'(bus.done), 32'd0);
        finished = 1;
        break;
      end
      if (abort_word >= 0 && bus.out_valid && n_hs == abort_word) begin
        bus.abort = 1'b1;
        aborted = 1;
        #1;
      end
      if (wr8 && !wrote && bus.out_valid && n_hs == 5) begin
        regs[8] = 32'hDEADBEEF;
        wrote = 1;
      end
      if (bus.busy) busy_cyc++;
      if (stalled_prev) check({tag, " valid held in stall"}, 32'(bus.out_valid), 32'd1);
      if (bus.out_valid) begin
        check({tag, " busy with valid"}, 32'(bus.busy), 32'd1);
        if (n_hs < n_exp) begin
          check({tag, " addr"}, 32'(bus.out_addr), 32'(l + n_hs));
          check({tag, " data"}, bus.out_data, exp_d[n_hs]);
        end else begin
          check({tag, " extra word"}, 32'd1, 32'd0);
        end
      end
      if (bus.done) begin
        done_cyc = c;
        check({tag, " words before done"}, 32'(n_hs), 32'(n_exp));
        check({tag, " valid in done"}, 32'(bus.out_valid), 32'd0);
        finished = 1;
        break;
      end
      stalled_prev = bus.out_valid && !bus.out_ready && !bus.abort;
      if (bus.out_valid && bus.out_ready && !bus.abort) begin
        n_hs++;
        wait_cnt = 0;
      end
    end
    check({tag, " finished in budget"}, 32'(finished), 32'd1);

    @(negedge clk);
    bus.start = 1'b0;
    bus.abort = 1'b0;
    #1;
    check({tag, " done one cycle"}, 32'(bus.done), 32'd0);
    if (!aborted) begin
      check({tag, " handshakes"}, 32'(n_hs), 32'(n_exp));
      if (n_exp == 0) check({tag, " busy never"}, 32'(busy_cyc), 32'd0);
      if (stall_pct == 0) begin
        check({tag, " done cycle"}, 32'(done_cyc), (n_exp == 0) ? 32'd1 : 32'(2 * n_exp + 1));
        check({tag, " busy cycles"}, 32'(busy_cyc), 32'(2 * n_exp));
      end
    end else begin
      check({tag, " no done on abort"}, 32'(done_cyc), 32'hFFFF_FFFF);
    end
  endtask

  initial begin
    int l, h;
    for (int i = 0; i < 32; i++) regs[i] = 32'd0;
    regs[29] = 32'h100;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.lo = '0;
    bus.hi = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("reset valid", 32'(bus.out_valid), 32'd0);
    check("reset busy", 32'(bus.busy), 32'd0);
    check("reset done", 32'(bus.done), 32'd0);
    check("reset ra", 32'(bus.ra), 32'd0);
    check("reset addr", 32'(bus.out_addr), 32'd0);
    check("reset data", bus.out_data, 32'd0);
    rst = 1'b0;

    run_dump(0, 31, 0, -1, 0, 0, "full");
    run_dump(3, 4, -1, -1, 0, 0, "backpressure");
    run_dump(31, 31, 0, -1, 0, 0, "single31");
    run_dump(7, 2, 0, -1, 0, 0, "empty");
    run_dump(0, 31, 0, 2, 0, 0, "abort");
    run_dump(16, 16, 0, -1, 0, 0, "restart16");

    // Asynchronous reset between edges while word 29 sits in SEND.
    @(negedge clk);
    bus.start = 1'b1; bus.lo = 5'd29; bus.hi = 5'd31; bus.out_ready = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    #1;
    check("rst pre valid", 32'(bus.out_valid), 32'd1);
    check("rst pre data", bus.out_data, 32'h100);
    #1 rst = 1'b1;
    #1;
    check("rst mid valid", 32'(bus.out_valid), 32'd0);
    check("rst mid addr", 32'(bus.out_addr), 32'd0);
    check("rst mid data", bus.out_data, 32'd0);
    check("rst mid busy", 32'(bus.busy), 32'd0);
    check("rst mid done", 32'(bus.done), 32'd0);
    check("rst mid ra", 32'(bus.ra), 32'd0);
    #1 rst = 1'b0;
    @(negedge clk);
    #1;
    check("rst idle busy", 32'(bus.busy), 32'd0);
    check("rst idle valid", 32'(bus.out_valid), 32'd0);

    run_dump(0, 10, 0, -1, 1, 1, "write8");

    for (int t = 0; t < 6; t++) begin
      for (int i = 1; i < 32; i++) regs[i] = $urandom;
      l = $urandom_range(31);
      h = $urandom_range(31);
      if (l > h) begin
        int tmp;
        tmp = l; l = h; h = tmp;
      end
      run_dump(l, h, 30, -1, 0, 0, "random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/regfile_dump.md
# regfile_dump

Sequential reader that walks a contiguous range of the 32×32 register file through one combinational read port and streams each `{index, value}` pair out over a valid/ready handshake. It sits beside the datapath register file, drives that file's third read-address port, and feeds the debug/trace path. It never writes the register file.

## Interface
- `AW`, 5: register index width.
- `DW`, 32: register data width.

- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  begin a dump; sampled only in IDLE.
- `abort`  in  1  synchronous cancel; returns to IDLE next edge.
- `lo`  in  AW  first index; sampled with `start`.
- `hi`  in  AW  last index, inclusive; sampled with `start`.
- `ra`  out  AW  read address to the register file port.
- `rd`  in  DW  combinational read data for `ra`; index 0 returns 0.
- `out_valid`  out  1  `out_addr`/`out_data` hold a word.
- `out_ready`  in  1  consumer accepts the word when high with `out_valid`.
- `out_addr`  out  AW  index of the presented word.
- `out_data`  out  DW  value of the presented word.
- `busy`  out  1  high in READ or SEND.
- `done`  out  1  one-cycle pulse when a dump completes normally.

## Operation
- One clock and one reset. Reset is asynchronous and active-high.
- The FSM has four states: IDLE, READ, SEND, FIN.
- **IDLE**
  - `start`=1 with `lo`≤`hi`: latch `hi` into `last`, set `ra`←`lo`, go to READ.
  - `start`=1 with `lo`>`hi`: go to FIN. No word is emitted.
- **READ**
  - Set `out_data`←`rd`, `out_addr`←`ra`, `out_valid`←1, go to SEND.
- **SEND**
  - Hold `out_valid`, `out_addr` and `out_data` stable until `out_valid & out_ready`.
  - On handshake with `ra`==`last`: `out_valid`←0, go to FIN.
  - On handshake otherwise: `ra`←`ra`+1, `out_valid`←0, go to READ.
- **FIN**
  - `done`=1 for this cycle only, then go to IDLE.
- **abort**
  - In READ, SEND or FIN: next state is IDLE, `out_valid`←0, no `done` pulse.
  - `abort` has priority over the handshake and over `start`.
- `start` outside IDLE is ignored. A `start` asserted in the FIN cycle is also ignored.
- `ra` is AW bits wide. Because `hi`≤31, the increment never wraps. When `hi`=31 the dump ends on `last` compare, not on overflow.
- The value sent is the file contents at the READ cycle. Writes that land after that cycle are not reflected. No coherency with concurrent writeback is provided.
- `out_data` and `out_addr` keep their last values when `out_valid`=0.

## Timing
- Reset values: state IDLE; `ra`, `out_addr`, `out_data`, `last` = 0; `out_valid`, `busy`, `done` = 0.
- `busy` is decoded from the state: 1 in READ or SEND, 0 in IDLE or FIN.
- Let `start` be sampled at edge E0.
  - READ during cycle E0→E1.
  - First `out_valid` high after E1.
- With `out_ready` held high:
  - One word every 2 cycles.
  - An N-word dump keeps `busy` high for 2N cycles.
  - `done` is high the cycle after the last handshake edge.
- With `lo`>`hi`: `done` is high in the cycle after E0; `busy` never rises.
- Back-to-back dumps: earliest re-`start` is sampled in the IDLE cycle right after FIN.
- Reset mid-dump: all outputs return to reset values immediately, without waiting for a clock edge. Any pending word is dropped.

## Test plan
- Full dump, `lo`=0, `hi`=31, `out_ready`=1, register file at power-on state.
  - 32 words, addresses 0..31.
  - Data 0, except index 29 = 0x100.
  - `done` pulses once, 64 cycles after the `start` edge.
- Backpressure: `lo`=3, `hi`=4, `out_ready` low 5 cycles on each word.
  - `out_valid`, `out_addr` and `out_data` stay stable while stalled.
  - Exactly 2 handshakes, at addresses 3 then 4.
- Single and empty ranges.
  - `lo`=`hi`=31: one word at address 31, then `done`.
  - `lo`=7, `hi`=2: zero words, `done` one cycle after `start`, `busy` stays 0.
- Abort and re-start.
  - `abort` in SEND of word 2 of a 0..31 dump: `out_valid` is 0 next cycle, no `done`.
  - A new `start` with `lo`=`hi`=16 then emits one word at address 16.
- Async reset mid-dump: `rst` pulses between clock edges during SEND. All outputs read 0 before the next edge, and the FSM is in IDLE.
- Write during dump: write 0xDEADBEEF to reg 8 while word 5 is in SEND of a 0..10 dump. The word at address 8 carries 0xDEADBEEF. `start` pulses while `busy` are ignored, giving exactly 11 words.
